// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage pipeline: load-use stall detection and
// registered EX operand-forwarding selects, tracking producers in EX/MEM/WB.
module hazard_scoreboard #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs_sel,
  input  logic                id_rs_used,
  input  logic [REG_BITS-1:0] id_rt_sel,
  input  logic                id_rt_used,
  input  logic [REG_BITS-1:0] id_wr_sel,
  input  logic                id_wr_en,
  input  logic                id_is_load,
  output logic                stall_id,
  output logic [1:0]          ex_fwd_rs,
  output logic [1:0]          ex_fwd_rt,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b10;

  logic                ex_valid, ex_we, ex_ld;
  logic [REG_BITS-1:0] ex_sel;
  logic                mem_valid, mem_we, mem_ld;
  logic [REG_BITS-1:0] mem_sel;
  logic                wb_valid, wb_we, wb_ld;
  logic [REG_BITS-1:0] wb_sel;

  logic ex_live, mem_live, wb_live;
  logic rs_ex_hit, rs_mem_hit, rs_wb_hit;
  logic rt_ex_hit, rt_mem_hit, rt_wb_hit;
  logic accept;
  logic [1:0] rs_next, rt_next;

  assign ex_live  = ex_valid & ex_we;
  assign mem_live = mem_valid & mem_we;
  assign wb_live  = wb_valid & wb_we;

  assign rs_ex_hit  = id_rs_used & ex_live  & (id_rs_sel == ex_sel);
  assign rs_mem_hit = id_rs_used & mem_live & (id_rs_sel == mem_sel);
  assign rs_wb_hit  = id_rs_used & wb_live  & (id_rs_sel == wb_sel);
  assign rt_ex_hit  = id_rt_used & ex_live  & (id_rt_sel == ex_sel);
  assign rt_mem_hit = id_rt_used & mem_live & (id_rt_sel == mem_sel);
  assign rt_wb_hit  = id_rt_used & wb_live  & (id_rt_sel == wb_sel);

  // flush masks the stall so the two are never asserted together
  assign stall_id = id_valid & ~flush & (rs_ex_hit | rt_ex_hit) & ex_ld;
  assign accept   = id_valid & ~flush & ~stall_id;

  // Youngest producer wins; a WB producer is served by the register-file bypass.
  always_comb begin
    rs_next = SEL_RF;
    if (rs_ex_hit && !ex_ld)  rs_next = SEL_EXM;
    else if (rs_mem_hit)      rs_next = SEL_MWB;
    else if (rs_wb_hit)       rs_next = SEL_RF;
  end

  always_comb begin
    rt_next = SEL_RF;
    if (rt_ex_hit && !ex_ld)  rt_next = SEL_EXM;
    else if (rt_mem_hit)      rt_next = SEL_MWB;
    else if (rt_wb_hit)       rt_next = SEL_RF;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid  <= 1'b0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      ex_sel    <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_ld    <= 1'b0;
      mem_sel   <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_ld     <= 1'b0;
      wb_sel    <= '0;
      ex_fwd_rs <= SEL_RF;
      ex_fwd_rt <= SEL_RF;
      stall_cnt <= '0;
    end else if (!freeze) begin
      wb_valid  <= mem_valid;
      wb_we     <= mem_we;
      wb_ld     <= mem_ld;
      wb_sel    <= mem_sel;
      mem_valid <= ex_valid;
      mem_we    <= ex_we;
      mem_ld    <= ex_ld;
      mem_sel   <= ex_sel;
      if (accept) begin
        ex_valid  <= 1'b1;
        ex_we     <= id_wr_en;
        ex_ld     <= id_is_load;
        ex_sel    <= id_wr_sel;
        ex_fwd_rs <= rs_next;
        ex_fwd_rt <= rt_next;
      end else begin
        ex_valid  <= 1'b0;
        ex_we     <= 1'b0;
        ex_ld     <= 1'b0;
        ex_sel    <= '0;
        ex_fwd_rs <= SEL_RF;
        ex_fwd_rt <= SEL_RF;
      end
      if (stall_id && (stall_cnt != {CNT_BITS{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios with literal
// expectations plus randomized traffic against an in-flight instruction model.
module tb_hazard_scoreboard;
  localparam int RB = 3;
  localparam int CB = 10;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic freeze = 1'b0, flush = 1'b0, id_valid = 1'b0;
  logic [RB-1:0] id_rs_sel = '0, id_rt_sel = '0, id_wr_sel = '0;
  logic id_rs_used = 1'b0, id_rt_used = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0;
  logic stall_id;
  logic [1:0] ex_fwd_rs, ex_fwd_rt;
  logic [CB-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  bit check_en = 0;

  hazard_scoreboard #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .id_valid(id_valid),
    .id_rs_sel(id_rs_sel), .id_rs_used(id_rs_used),
    .id_rt_sel(id_rt_sel), .id_rt_used(id_rt_used),
    .id_wr_sel(id_wr_sel), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .stall_id(stall_id), .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: list of in-flight instructions, index 0 = youngest (EX).
  typedef struct { bit v; int dst; bit we; bit ld; } instr_t;
  instr_t pipe[3];
  instr_t npipe[3];
  int m_rs = 0, m_rt = 0, m_cnt = 0;
  int n_rs = 0, n_rt = 0, n_cnt = 0;

  function automatic bit writes(instr_t i, int r);
    return i.v && i.we && (i.dst == r);
  endfunction

  function automatic int src_select(bit used, int r, instr_t e, instr_t m);
    if (!used) return 0;
    if (writes(e, r) && !e.ld) return 1;
    if (writes(m, r)) return 2;
    return 0;
  endfunction

  function automatic bit model_stall(instr_t e);
    if (!id_valid || flush || !e.ld) return 0;
    return (id_rs_used && writes(e, int'(id_rs_sel))) ||
           (id_rt_used && writes(e, int'(id_rt_sel)));
  endfunction

  task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Compare process and model next-state evaluation
  always @(negedge clk) begin
    bit s;
    s = model_stall(pipe[0]);
    if (check_en) begin
      expect_val("model_stall_id", {31'd0, stall_id}, {31'd0, s});
      expect_val("model_fwd_rs", {30'd0, ex_fwd_rs}, m_rs);
      expect_val("model_fwd_rt", {30'd0, ex_fwd_rt}, m_rt);
      expect_val("model_stall_cnt", {22'd0, stall_cnt}, m_cnt);
    end
    npipe = pipe; n_rs = m_rs; n_rt = m_rt; n_cnt = m_cnt;
    if (!rst) begin
      for (int i = 0; i < 3; i++) npipe[i] = '{0, 0, 0, 0};
      n_rs = 0; n_rt = 0; n_cnt = 0;
    end else if (!freeze) begin
      npipe[2] = pipe[1];
      npipe[1] = pipe[0];
      if (id_valid && !flush && !s) begin
        npipe[0] = '{1, int'(id_wr_sel), id_wr_en, id_is_load};
        n_rs = src_select(id_rs_used, int'(id_rs_sel), pipe[0], pipe[1]);
        n_rt = src_select(id_rt_used, int'(id_rt_sel), pipe[0], pipe[1]);
      end else begin
        npipe[0] = '{0, 0, 0, 0};
        n_rs = 0; n_rt = 0;
      end
      if (s && m_cnt < CNT_MAX) n_cnt = m_cnt + 1;
    end
  end

  always @(posedge clk) begin
    pipe = npipe; m_rs = n_rs; m_rt = n_rt; m_cnt = n_cnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int wr, input bit we, input bit ld);
    id_valid = v; id_rs_sel = RB'(rs); id_rs_used = rsu; id_rt_sel = RB'(rt);
    id_rt_used = rtu; id_wr_sel = RB'(wr); id_wr_en = we; id_is_load = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; idle();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    check_en = 1;
    @(negedge clk);
    expect_val("reset_stall", {31'd0, stall_id}, 0);
    expect_val("reset_fwd_rs", {30'd0, ex_fwd_rs}, 0);
    expect_val("reset_cnt", {22'd0, stall_cnt}, 0);

    // ADD r1 ; ADD r2,r1,r3
    tick();
    drive(1, 2, 1, 3, 1, 1, 1, 0); tick();
    drive(1, 1, 1, 3, 1, 2, 1, 0);
    @(negedge clk); expect_val("alu_dep_no_stall", {31'd0, stall_id}, 0);
    tick(); idle();
    @(negedge clk);
    expect_val("alu_dep_fwd_rs", {30'd0, ex_fwd_rs}, 1);
    expect_val("alu_dep_fwd_rt", {30'd0, ex_fwd_rt}, 0);

    // LD r4 ; ADD r5,r4,r4
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1); tick();
    drive(1, 4, 1, 4, 1, 5, 1, 0);
    @(negedge clk); expect_val("ld_use_stall", {31'd0, stall_id}, 1);
    tick();
    @(negedge clk); expect_val("ld_use_stall_once", {31'd0, stall_id}, 0);
    tick(); idle();
    @(negedge clk);
    expect_val("ld_use_fwd_rs", {30'd0, ex_fwd_rs}, 2);
    expect_val("ld_use_fwd_rt", {30'd0, ex_fwd_rt}, 2);
    expect_val("ld_use_cnt", {22'd0, stall_cnt}, 1);

    // load-use hazard held under freeze for 3 edges
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1); tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0); freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_val("frz_stall", {31'd0, stall_id}, 1);
      expect_val("frz_cnt", {22'd0, stall_cnt}, 0);
      tick();
    end
    freeze = 1'b0;
    @(negedge clk); expect_val("frz_release_stall", {31'd0, stall_id}, 1);
    tick();
    @(negedge clk); expect_val("frz_release_cnt", {22'd0, stall_cnt}, 1);

    // r2 written by EX and MEM: youngest wins
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 2, 1, 0); tick();
    drive(1, 2, 1, 0, 0, 6, 1, 0); tick(); idle();
    @(negedge clk); expect_val("youngest_fwd_rs", {30'd0, ex_fwd_rs}, 1);
    // producer two ahead -> 10, three ahead -> 00
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0); tick(); idle(); tick();
    drive(1, 2, 1, 2, 1, 6, 1, 0); tick(); idle();
    @(negedge clk); expect_val("mem_fwd_rt", {30'd0, ex_fwd_rt}, 2);
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 1, 0); tick(); idle(); tick(); tick();
    drive(1, 2, 1, 0, 0, 6, 1, 0); tick(); idle();
    @(negedge clk); expect_val("wb_fwd_rs", {30'd0, ex_fwd_rs}, 0);

    // flush during load-use hazard
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1); tick();
    drive(1, 4, 1, 4, 1, 5, 1, 0); flush = 1'b1;
    @(negedge clk); expect_val("flush_masks_stall", {31'd0, stall_id}, 0);
    tick(); flush = 1'b0;
    @(negedge clk);
    expect_val("flush_fwd_rs", {30'd0, ex_fwd_rs}, 0);
    expect_val("flush_cnt", {22'd0, stall_cnt}, 0);
    expect_val("flush_bubble_no_stall", {31'd0, stall_id}, 0);
    tick(); idle();
    @(negedge clk); expect_val("flush_then_mem_fwd", {30'd0, ex_fwd_rs}, 2);

    // counter saturation: LD r4 that reads r4 stalls every second cycle
    do_reset();
    drive(1, 4, 1, 0, 0, 4, 1, 1);
    for (int i = 0; i < 2 * CNT_MAX; i++) tick();
    @(negedge clk);
    expect_val("sat_reach_max", {22'd0, stall_cnt}, CNT_MAX);
    tick();
    @(negedge clk); expect_val("sat_stall_again", {31'd0, stall_id}, 1);
    tick();
    @(negedge clk); expect_val("sat_hold_max", {22'd0, stall_cnt}, CNT_MAX);
    rst = 1'b0; tick(); rst = 1'b1;
    @(negedge clk);
    expect_val("post_rst_cnt", {22'd0, stall_cnt}, 0);
    expect_val("post_rst_fwd_rs", {30'd0, ex_fwd_rs}, 0);
    expect_val("post_rst_fwd_rt", {30'd0, ex_fwd_rt}, 0);
    expect_val("post_rst_stall", {31'd0, stall_id}, 0);

    // randomized traffic, narrow register range for frequent hazards
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst    = ($urandom_range(0, 99) != 0);
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0);
    end
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
